// File: rtl/p_pattern_detect.sv
// Pattern detector behind the DSP slice P register: masked pattern / complement
// matches, overflow/underflow events, P auto-reset request, sticky status and match counter.
module p_pattern_detect #(
    parameter logic [47:0] PATTERN   = 48'h0,
    parameter logic [47:0] MASK      = 48'h3FFF_FFFF_FFFF,
    parameter int          PDREG     = 1,
    parameter int          AUTORESET = 0
) (
    input  logic               CLK,
    input  logic               RSTPD_N,
    input  logic               CEPD,
    input  logic               CLR_STICKY,
    input  logic signed [47:0] P_IN,
    output logic               PATTERNDETECT,
    output logic               PATTERNBDETECT,
    output logic               PATTERNDETECTPAST,
    output logic               PATTERNBDETECTPAST,
    output logic               OVERFLOW,
    output logic               UNDERFLOW,
    output logic               AUTORESET_P,
    output logic               OVF_STICKY,
    output logic               UNF_STICKY,
    output logic [15:0]        MATCH_CNT
);

    logic        pd_raw;
    logic        pbd_raw;
    logic        ar_next;
    logic        pd_past;
    logic        pbd_past;
    logic        ar_q;
    logic        ovf_s;
    logic        unf_s;
    logic [15:0] cnt_q;
    logic [15:0] cnt_base;
    logic [15:0] cnt_next;

    // Masked bits (MASK=1) always count as matching.
    assign pd_raw  = &(~(P_IN ^ PATTERN) | MASK);
    assign pbd_raw = &((P_IN ^ PATTERN) | MASK);

    generate
        if (PDREG == 1) begin : g_flag_reg
            logic pd_q;
            logic pbd_q;
            always_ff @(posedge CLK or negedge RSTPD_N) begin
                if (!RSTPD_N) begin
                    pd_q  <= 1'b0;
                    pbd_q <= 1'b0;
                end else if (CEPD) begin
                    pd_q  <= pd_raw;
                    pbd_q <= pbd_raw;
                end
            end
            assign PATTERNDETECT  = pd_q;
            assign PATTERNBDETECT = pbd_q;
        end else begin : g_flag_comb
            assign PATTERNDETECT  = pd_raw;
            assign PATTERNBDETECT = pbd_raw;
        end
    endgenerate

    // The next detect value is pd_raw in both flag modes: the registered flag loads pd_raw.
    always_comb begin
        ar_next = 1'b0;
        case (AUTORESET)
            1:       ar_next = pd_raw;
            2:       ar_next = PATTERNDETECT & ~pd_raw;
            default: ar_next = 1'b0;
        endcase
    end

    // A clear and an event in the same cycle: the event lands on the cleared value.
    assign cnt_base = CLR_STICKY ? 16'h0000 : cnt_q;
    assign cnt_next = (PATTERNDETECT && cnt_base != 16'hFFFF) ? cnt_base + 16'd1 : cnt_base;

    always_ff @(posedge CLK or negedge RSTPD_N) begin
        if (!RSTPD_N) begin
            pd_past  <= 1'b0;
            pbd_past <= 1'b0;
            ar_q     <= 1'b0;
            ovf_s    <= 1'b0;
            unf_s    <= 1'b0;
            cnt_q    <= 16'h0000;
        end else if (CEPD) begin
            pd_past  <= PATTERNDETECT;
            pbd_past <= PATTERNBDETECT;
            ar_q     <= ar_next;
            ovf_s    <= (ovf_s & ~CLR_STICKY) | OVERFLOW;
            unf_s    <= (unf_s & ~CLR_STICKY) | UNDERFLOW;
            cnt_q    <= cnt_next;
        end
    end

    assign PATTERNDETECTPAST  = pd_past;
    assign PATTERNBDETECTPAST = pbd_past;
    assign OVERFLOW           = pd_past & ~PATTERNDETECT & ~PATTERNBDETECT;
    assign UNDERFLOW          = pbd_past & ~PATTERNDETECT & ~PATTERNBDETECT;
    assign AUTORESET_P        = ar_q;
    assign OVF_STICKY         = ovf_s;
    assign UNF_STICKY         = unf_s;
    assign MATCH_CNT          = cnt_q;

endmodule

// File: tb/tb_p_pattern_detect.sv
// Bench for p_pattern_detect: four configurations share one stimulus stream and are
// compared against a behavioural model of the detector rules.
module tb_p_pattern_detect;

    localparam int N = 4;

    logic               CLK = 1'b0;
    logic               RSTPD_N;
    logic               CEPD;
    logic               CLR_STICKY;
    logic signed [47:0] P_IN;

    logic [N-1:0] pd_o, pbd_o, ppd_o, ppbd_o, ovf_o, unf_o, ar_o, ovfs_o, unfs_o;
    logic [15:0]  cnt_o [N];

    int checks   = 0;
    int failures = 0;
    int step     = 0;

    always #5 CLK = ~CLK;

    // Instance 0: defaults. 1/2: exact match on 100 with auto-reset modes 1/2. 3: unregistered flags, mode 1.
    function automatic logic [47:0] cfg_pat(int i);
        return (i == 0) ? 48'h0 : 48'd100;
    endfunction
    function automatic logic [47:0] cfg_mask(int i);
        return (i == 0) ? 48'h3FFF_FFFF_FFFF : 48'h0;
    endfunction
    function automatic int cfg_pdreg(int i);
        return (i == 3) ? 0 : 1;
    endfunction
    function automatic int cfg_ar(int i);
        return (i == 0) ? 0 : ((i == 2) ? 2 : 1);
    endfunction

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            p_pattern_detect #(
                .PATTERN  (cfg_pat(g)),
                .MASK     (cfg_mask(g)),
                .PDREG    (cfg_pdreg(g)),
                .AUTORESET(cfg_ar(g))
            ) u_dut (
                .CLK               (CLK),
                .RSTPD_N           (RSTPD_N),
                .CEPD              (CEPD),
                .CLR_STICKY        (CLR_STICKY),
                .P_IN              (P_IN),
                .PATTERNDETECT     (pd_o[g]),
                .PATTERNBDETECT    (pbd_o[g]),
                .PATTERNDETECTPAST (ppd_o[g]),
                .PATTERNBDETECTPAST(ppbd_o[g]),
                .OVERFLOW          (ovf_o[g]),
                .UNDERFLOW         (unf_o[g]),
                .AUTORESET_P       (ar_o[g]),
                .OVF_STICKY        (ovfs_o[g]),
                .UNF_STICKY        (unfs_o[g]),
                .MATCH_CNT         (cnt_o[g])
            );
        end
    endgenerate

    // Reference model state
    bit m_pd [N], m_pbd [N], m_ppd [N], m_ppbd [N], m_ar [N], m_ovfs [N], m_unfs [N];
    int m_cnt [N];

    function automatic bit hit(int i, logic [47:0] p, bit comp);
        logic [47:0] tgt;
        tgt = comp ? ~cfg_pat(i) : cfg_pat(i);
        return ((p ^ tgt) & ~cfg_mask(i)) == 48'h0;
    endfunction
    function automatic bit e_pd(int i);
        return (cfg_pdreg(i) == 1) ? m_pd[i] : hit(i, P_IN, 1'b0);
    endfunction
    function automatic bit e_pbd(int i);
        return (cfg_pdreg(i) == 1) ? m_pbd[i] : hit(i, P_IN, 1'b1);
    endfunction
    function automatic bit e_ovf(int i);
        return m_ppd[i] && !e_pd(i) && !e_pbd(i);
    endfunction
    function automatic bit e_unf(int i);
        return m_ppbd[i] && !e_pd(i) && !e_pbd(i);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pd[i] = 0; m_pbd[i] = 0; m_ppd[i] = 0; m_ppbd[i] = 0;
            m_ar[i] = 0; m_ovfs[i] = 0; m_unfs[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_step();
        bit cur_pd, cur_pbd, ovf, unf, nxt;
        if (!CEPD) return;
        for (int i = 0; i < N; i++) begin
            cur_pd  = e_pd(i);
            cur_pbd = e_pbd(i);
            ovf     = e_ovf(i);
            unf     = e_unf(i);
            nxt     = hit(i, P_IN, 1'b0);
            m_ppd[i]  = cur_pd;
            m_ppbd[i] = cur_pbd;
            m_pd[i]   = nxt;
            m_pbd[i]  = hit(i, P_IN, 1'b1);
            case (cfg_ar(i))
                1:       m_ar[i] = nxt;
                2:       m_ar[i] = cur_pd && !nxt;
                default: m_ar[i] = 0;
            endcase
            if (CLR_STICKY) begin
                m_ovfs[i] = 0;
                m_unfs[i] = 0;
                m_cnt[i]  = 0;
            end
            if (ovf) m_ovfs[i] = 1;
            if (unf) m_unfs[i] = 1;
            if (cur_pd) m_cnt[i] = (m_cnt[i] + 1 > 65535) ? 65535 : m_cnt[i] + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s#%0d.u%0d.pd",   ph, step, i), 16'(pd_o[i]),   16'(e_pd(i)));
            chk($sformatf("%s#%0d.u%0d.pbd",  ph, step, i), 16'(pbd_o[i]),  16'(e_pbd(i)));
            chk($sformatf("%s#%0d.u%0d.ppd",  ph, step, i), 16'(ppd_o[i]),  16'(m_ppd[i]));
            chk($sformatf("%s#%0d.u%0d.ppbd", ph, step, i), 16'(ppbd_o[i]), 16'(m_ppbd[i]));
            chk($sformatf("%s#%0d.u%0d.ovf",  ph, step, i), 16'(ovf_o[i]),  16'(e_ovf(i)));
            chk($sformatf("%s#%0d.u%0d.unf",  ph, step, i), 16'(unf_o[i]),  16'(e_unf(i)));
            chk($sformatf("%s#%0d.u%0d.ar",   ph, step, i), 16'(ar_o[i]),   16'(m_ar[i]));
            chk($sformatf("%s#%0d.u%0d.ovfs", ph, step, i), 16'(ovfs_o[i]), 16'(m_ovfs[i]));
            chk($sformatf("%s#%0d.u%0d.unfs", ph, step, i), 16'(unfs_o[i]), 16'(m_unfs[i]));
            chk($sformatf("%s#%0d.u%0d.cnt",  ph, step, i), cnt_o[i],       16'(m_cnt[i]));
        end
    endtask

    // Driver: apply inputs after the falling edge, check, then take one rising edge.
    task automatic tick(input logic [47:0] p, input bit ce, input bit clr, input bit do_chk);
        step++;
        P_IN       = p;
        CEPD       = ce;
        CLR_STICKY = clr;
        #1;
        if (do_chk) check_all("tick");
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        #1;
    endtask

    function automatic logic [47:0] rand_p();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 5))
            0:       return 48'd98 + 48'($urandom_range(0, 4));
            1:       return {2'b00, r[45:0]};
            2:       return {2'b11, r[45:0]};
            3:       return r[47:0];
            4:       return ~48'd100;
            default: return 48'h0;
        endcase
    endfunction

    initial begin
        RSTPD_N    = 1'b0;
        CEPD       = 1'b0;
        CLR_STICKY = 1'b0;
        P_IN       = '0;
        model_reset();
        @(negedge CLK);
        #1;
        check_all("init");
        @(negedge CLK);
        RSTPD_N = 1'b1;

        // Random warm-up, then asynchronous reset between edges
        for (int k = 0; k < 40; k++) tick(rand_p(), 1'b1, ($urandom_range(0, 9) == 0), 1'b1);
        P_IN = rand_p();
        #2;
        RSTPD_N = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        chk("reset.cnt0", cnt_o[0], 16'h0000);
        chk("reset.ovf0", 16'(ovf_o[0]), 16'h0);
        @(negedge CLK);
        RSTPD_N = 1'b1;
        tick(48'h4000_0000_0000, 1'b1, 1'b0, 1'b1);
        chk("release.no_ovf", 16'(ovf_o[0]), 16'h0);

        // Overflow with defaults
        tick(48'h3FFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
        chk("ovf.pd_hi", 16'(pd_o[0]), 16'h1);
        tick(48'h4000_0000_0000, 1'b1, 1'b0, 1'b1);
        chk("ovf.pd_lo", 16'(pd_o[0]), 16'h0);
        chk("ovf.pulse", 16'(ovf_o[0]), 16'h1);
        tick(48'h4000_0000_0000, 1'b1, 1'b0, 1'b1);
        chk("ovf.pulse_end", 16'(ovf_o[0]), 16'h0);
        chk("ovf.sticky", 16'(ovfs_o[0]), 16'h1);

        // Underflow with defaults
        tick(48'hC000_0000_0000, 1'b1, 1'b1, 1'b1);
        chk("unf.pbd_hi", 16'(pbd_o[0]), 16'h1);
        tick(48'hBFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
        chk("unf.pbd_lo", 16'(pbd_o[0]), 16'h0);
        chk("unf.pulse", 16'(unf_o[0]), 16'h1);
        chk("unf.no_ovf", 16'(ovf_o[0]), 16'h0);
        tick(48'hBFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
        chk("unf.sticky", 16'(unfs_o[0]), 16'h1);

        // Auto-reset mode 1 on exact match of 100
        tick(48'd98, 1'b1, 1'b0, 1'b1);
        tick(48'd99, 1'b1, 1'b0, 1'b1);
        chk("ar1.idle", 16'(ar_o[1]), 16'h0);
        tick(48'd100, 1'b1, 1'b0, 1'b1);
        chk("ar1.pulse", 16'(ar_o[1]), 16'h1);
        chk("ar1c.pulse", 16'(ar_o[3]), 16'h1);
        tick(48'd101, 1'b1, 1'b0, 1'b1);
        chk("ar1.end", 16'(ar_o[1]), 16'h0);

        // Auto-reset mode 2: pulse when the match ends
        tick(48'd100, 1'b1, 1'b0, 1'b1);
        chk("ar2.during", 16'(ar_o[2]), 16'h0);
        tick(48'd101, 1'b1, 1'b0, 1'b1);
        chk("ar2.pulse", 16'(ar_o[2]), 16'h1);
        tick(48'd102, 1'b1, 1'b0, 1'b1);
        chk("ar2.end", 16'(ar_o[2]), 16'h0);

        // Randomized traffic including enable gaps and clears
        for (int k = 0; k < 400; k++)
            tick(rand_p(), ($urandom_range(0, 4) != 0), ($urandom_range(0, 9) == 0), 1'b1);

        // Counter saturation, clear with a simultaneous match, then freeze
        tick(48'h0, 1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 65540; k++) tick(48'h0, 1'b1, 1'b0, 1'b0);
        check_all("sat");
        chk("sat.cnt", cnt_o[0], 16'hFFFF);
        tick(48'h0, 1'b1, 1'b1, 1'b1);
        chk("clr.cnt", cnt_o[0], 16'h0001);
        for (int k = 0; k < 6; k++) tick(rand_p(), 1'b0, 1'b1, 1'b1);
        chk("freeze.cnt", cnt_o[0], 16'h0001);
        tick(48'h0, 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
